vgaterm_cmd: RTL and testbench
==============================

Name: vgaterm_cmd

Overview:
- Command interpreter that sits directly upstream of the VGA character terminal peripheral.
- Accepts a byte stream through a valid/ready handshake and decodes printable characters and control codes.
- Drives the terminal's data, dstb, rstb and cstb strobe interface.
- Keeps a shadow cursor that always matches the terminal's internal cursor.

Parameters:
ROWS, 30, screen rows; cursor row wraps from ROWS-1 to 0
COLS, 80, screen columns; cursor column wraps from COLS-1 to 0
TABW, 8, tab stop spacing (power of 2)
CLR_CHAR, 8'h20, character code written by clear-screen

Ports:
clk  in  1  system clock (one clock domain)
reset  in  1  asynchronous, active-high reset
in_data  in  8  command/character byte
in_valid  in  1  in_data valid
in_ready  out  1  block can accept a byte this cycle
data  out  8  to terminal data bus
dstb  out  1  to terminal: write char at cursor; the terminal auto-advances the cursor
rstb  out  1  to terminal: load cursor row from data
cstb  out  1  to terminal: load cursor column from data
currow  out  5  shadow cursor row
curcol  out  7  shadow cursor column
busy  out  1  high whenever the state is not IDLE or ESC-wait

Behaviour:
- Reset (asynchronous, active-high): data=0, dstb=rstb=cstb=0, currow=curcol=0, state=IDLE, in_ready=1, busy=0.
- Reset mid-operation aborts at once; the falling edge on any strobe is harmless.
- A byte is accepted on the clk edge where in_valid&&in_ready.
- in_ready is high only in IDLE, ESC1, ESC_ROW and ESC_COL.
- Strobe op: 3 cycles.
  - SETUP: data driven, strobe low.
  - PULSE: exactly one strobe high.
  - HOLD: strobe low.
  - data is stable for all 3 cycles. No two strobes are ever high together.
- Timing: accept at cycle N → SETUP N+1, PULSE N+2, HOLD N+3, in_ready=1 at N+4 (single-op command).
- Multi-op commands chain ops back-to-back.
- Ignored bytes: in_ready returns at N+1; no strobes.
- Decode in IDLE:
  - 0x20-0x7E and 0x80-0xFF: one dstb op with data=byte. Shadow col+1. At col COLS-1: col←0 and row←row+1, wrapping ROWS-1→0.
  - 0x0D CR: col←0; cstb op with data=0.
  - 0x0A LF: row←(row==ROWS-1)?0:row+1; rstb op with data=new row. Column unchanged.
  - 0x08 BS: if col>0, col←col-1 and cstb op. If col==0, ignored.
  - 0x09 TAB: col←min((col|(TABW-1))+1, COLS-1); cstb op. At col 79: cstb op with data=79.
  - 0x0C FF (clear): rstb op with data 0, then cstb op with data 0, then ROWS*COLS (2400) dstb ops with data=CLR_CHAR. The terminal cursor wraps back to 0,0. Shadow ends at 0,0. Total duration 3*2402 cycles.
  - 0x1B ESC: go to ESC1.
  - All other 0x00-0x1F codes and 0x7F: ignored.
- Escape cursor addressing (ESC '=' r c, bias 0x20):
  - ESC1: if the byte is 0x3D, go to ESC_ROW. Otherwise drop the byte and return to IDLE; the byte is not re-decoded.
  - ESC_ROW: latch r=byte-0x20, clamped to ROWS-1 if the byte is >0x20+ROWS-1 or <0x20 (wrapped underflow is clamped). Go to ESC_COL.
  - ESC_COL: c=byte-0x20, clamped to COLS-1 in the same way.
  - Then rstb op with data=r, then cstb op with data=c. Shadow ← (r,c).
- Clear counter: 12-bit, counts 0..ROWS*COLS-1.
- in_valid has no effect while busy. The source must hold in_data stable until it is accepted.

Test Plan:
- Reset, then 'A' (0x41) → data=0x41 at N+1; dstb high only at N+2; in_ready at N+4; curcol=1, currow=0.
- 80 bytes of 'x' starting at 0,0 → 80 dstb pulses; shadow ends at row 1, col 0. Repeat to row 29 col 79, then one more byte → wraps to 0,0.
- Col 5 then CR, LF, BS, TAB:
  - CR → cstb with data 0.
  - LF → rstb with data 1.
  - BS at col 0 → no strobe, in_ready at N+1.
  - TAB from col 3 → cstb with data 8.
  - TAB from col 78 → cstb with data 79.
- ESC '=' 0x25 0x2A → rstb with data 5, then cstb with data 10; currow=5, curcol=10. ESC '=' 0x7F 0x7F → clamps to 29,79. ESC 'Q' → no strobes, IDLE.
- 0x0C → rstb 0, cstb 0, exactly 2400 dstb pulses with data 0x20; busy for 7206 cycles; shadow ends at 0,0.
- Assert reset during the PULSE of a dstb op and during a clear → all strobes 0 immediately; in_ready=1 and shadow 0,0 after release. The next 'B' writes at 0,0.

Source files
------------

// File: rtl/vgaterm_cmd.sv
// Byte-stream command interpreter in front of the VGA character terminal.
// Turns bytes into setup/pulse/hold strobe ops and tracks a shadow cursor.
module vgaterm_cmd #(
  parameter int          ROWS     = 30,
  parameter int          COLS     = 80,
  parameter int          TABW     = 8,
  parameter logic [7:0]  CLR_CHAR = 8'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] data,
  output logic       dstb,
  output logic       rstb,
  output logic       cstb,
  output logic [4:0] currow,
  output logic [6:0] curcol,
  output logic       busy
);

  // Handshake: a byte transfers on the rising clk edge where in_valid && in_ready;
  // in_data must be held stable by the source until that edge.
  typedef enum logic [2:0] {
    S_IDLE, S_ESC1, S_ESC_ROW, S_ESC_COL, S_SETUP, S_PULSE, S_HOLD
  } state_t;
  typedef enum logic [1:0] {OP_D, OP_R, OP_C} op_t;
  typedef enum logic [1:0] {CH_NONE, CH_COL, CH_CLR_COL, CH_CLR_CHARS} chain_t;

  localparam logic [4:0]  ROW_MAX  = 5'(ROWS - 1);
  localparam logic [6:0]  COL_MAX  = 7'(COLS - 1);
  localparam logic [7:0]  ROW_LIM  = 8'(32 + ROWS - 1);
  localparam logic [7:0]  COL_LIM  = 8'(32 + COLS - 1);
  localparam logic [11:0] CLR_LAST = 12'(ROWS * COLS - 1);

  state_t      state, state_n;
  op_t         op, op_n;
  chain_t      chain, chain_n;
  logic [11:0] cnt, cnt_n;
  logic [4:0]  row_pend, row_pend_n, row_n, row_inc;
  logic [6:0]  col_pend, col_pend_n, col_n, tab_col, esc_col;
  logic [7:0]  data_n, tab_sum;
  logic        accept;

  function automatic logic [4:0] clamp_row(input logic [7:0] b);
    return (b < 8'h20 || b > ROW_LIM) ? ROW_MAX : 5'(b - 8'h20);
  endfunction

  function automatic logic [6:0] clamp_col(input logic [7:0] b);
    return (b < 8'h20 || b > COL_LIM) ? COL_MAX : 7'(b - 8'h20);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      op       <= OP_D;
      chain    <= CH_NONE;
      cnt      <= '0;
      row_pend <= '0;
      col_pend <= '0;
      data     <= '0;
      currow   <= '0;
      curcol   <= '0;
    end else begin
      state    <= state_n;
      op       <= op_n;
      chain    <= chain_n;
      cnt      <= cnt_n;
      row_pend <= row_pend_n;
      col_pend <= col_pend_n;
      data     <= data_n;
      currow   <= row_n;
      curcol   <= col_n;
    end
  end

  always_comb begin
    state_n    = state;
    op_n       = op;
    chain_n    = chain;
    cnt_n      = cnt;
    row_pend_n = row_pend;
    col_pend_n = col_pend;
    data_n     = data;
    row_n      = currow;
    col_n      = curcol;
    in_ready   = (state == S_IDLE) || (state == S_ESC1) ||
                 (state == S_ESC_ROW) || (state == S_ESC_COL);
    busy       = !in_ready;
    accept     = in_valid && in_ready;
    dstb       = (state == S_PULSE) && (op == OP_D);
    rstb       = (state == S_PULSE) && (op == OP_R);
    cstb       = (state == S_PULSE) && (op == OP_C);
    row_inc    = (currow == ROW_MAX) ? 5'd0 : currow + 5'd1;
    tab_sum    = ({1'b0, curcol} | 8'(TABW - 1)) + 8'd1;
    tab_col    = (tab_sum > {1'b0, COL_MAX}) ? COL_MAX : tab_sum[6:0];
    esc_col    = clamp_col(in_data);

    case (state)
      S_IDLE: begin
        if (accept) begin
          if (in_data == 8'h1B) begin
            state_n = S_ESC1;
          end else if (in_data == 8'h0D) begin
            col_n = '0; op_n = OP_C; data_n = '0; state_n = S_SETUP;
          end else if (in_data == 8'h0A) begin
            row_n = row_inc; op_n = OP_R; data_n = {3'b0, row_inc}; state_n = S_SETUP;
          end else if (in_data == 8'h08) begin
            if (curcol != '0) begin
              col_n = curcol - 7'd1; op_n = OP_C;
              data_n = {1'b0, curcol - 7'd1}; state_n = S_SETUP;
            end
          end else if (in_data == 8'h09) begin
            col_n = tab_col; op_n = OP_C; data_n = {1'b0, tab_col}; state_n = S_SETUP;
          end else if (in_data == 8'h0C) begin
            // Clear: home both axes, then fill every cell; the terminal wraps back to 0,0.
            row_n = '0; col_n = '0; op_n = OP_R; data_n = '0;
            chain_n = CH_CLR_COL; state_n = S_SETUP;
          end else if (in_data >= 8'h20 && in_data != 8'h7F) begin
            op_n = OP_D; data_n = in_data; state_n = S_SETUP;
            if (curcol == COL_MAX) begin
              col_n = '0; row_n = row_inc;
            end else begin
              col_n = curcol + 7'd1;
            end
          end
        end
      end
      S_ESC1: begin
        if (accept) state_n = (in_data == 8'h3D) ? S_ESC_ROW : S_IDLE;
      end
      S_ESC_ROW: begin
        if (accept) begin
          row_pend_n = clamp_row(in_data);
          state_n    = S_ESC_COL;
        end
      end
      S_ESC_COL: begin
        if (accept) begin
          row_n = row_pend; col_n = esc_col; col_pend_n = esc_col;
          op_n = OP_R; data_n = {3'b0, row_pend};
          chain_n = CH_COL; state_n = S_SETUP;
        end
      end
      S_SETUP: state_n = S_PULSE;
      S_PULSE: state_n = S_HOLD;
      S_HOLD: begin
        case (chain)
          CH_COL: begin
            op_n = OP_C; data_n = {1'b0, col_pend}; chain_n = CH_NONE; state_n = S_SETUP;
          end
          CH_CLR_COL: begin
            op_n = OP_C; data_n = '0; chain_n = CH_CLR_CHARS; state_n = S_SETUP;
          end
          CH_CLR_CHARS: begin
            if (op == OP_C) begin
              op_n = OP_D; data_n = CLR_CHAR; cnt_n = '0; state_n = S_SETUP;
            end else if (cnt == CLR_LAST) begin
              chain_n = CH_NONE; state_n = S_IDLE;
            end else begin
              cnt_n = cnt + 12'd1; state_n = S_SETUP;
            end
          end
          default: state_n = S_IDLE;
        endcase
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_vgaterm_cmd.sv
// Self-checking bench for vgaterm_cmd: a behavioural cursor/strobe model feeds an
// expected-event queue that a strobe monitor drains.
module tb_vgaterm_cmd;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] data;
  logic       dstb, rstb, cstb;
  logic [4:0] currow;
  logic [6:0] curcol;
  logic       busy;

  vgaterm_cmd dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .data(data), .dstb(dstb), .rstb(rstb), .cstb(cstb),
    .currow(currow), .curcol(curcol), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_dstb  = 0;
  logic [9:0] exp_q[$];
  logic [9:0] mon_got, mon_exp;

  // Model state: cursor and escape-sequence progress.
  int m_row = 0, m_col = 0, m_esc = 0, m_r = 0;

  // Event encoding {kind, data}: kind 1=dstb, 2=rstb, 3=cstb.
  always @(negedge clk) begin
    if (!reset && (dstb || rstb || cstb)) begin
      mon_got = {(dstb ? 2'd1 : (rstb ? 2'd2 : 2'd3)), data};
      n_tests++;
      if (dstb) n_dstb++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL strobe_event: got kind/data=%h, required no strobe", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if ($countones({dstb, rstb, cstb}) != 1 || mon_got !== mon_exp) begin
          n_fail++;
          $display("FAIL strobe_event: got d=%b r=%b c=%b kind/data=%h, required %h",
                   dstb, rstb, cstb, mon_got, mon_exp);
        end
      end
    end
  end

  function automatic void push_ev(input int k, input int d);
    exp_q.push_back({2'(k), 8'(d)});
  endfunction

  task automatic model_byte(input logic [7:0] b);
    int c;
    case (m_esc)
      1: m_esc = (b == 8'h3D) ? 2 : 0;
      2: begin
        m_r   = (b < 8'h20 || b > 8'h20 + 29) ? 29 : int'(b) - 32;
        m_esc = 3;
      end
      3: begin
        c = (b < 8'h20 || b > 8'h20 + 79) ? 79 : int'(b) - 32;
        push_ev(2, m_r);
        push_ev(3, c);
        m_row = m_r; m_col = c; m_esc = 0;
      end
      default: begin
        if (b == 8'h1B) m_esc = 1;
        else if (b == 8'h0D) begin m_col = 0; push_ev(3, 0); end
        else if (b == 8'h0A) begin m_row = (m_row + 1) % 30; push_ev(2, m_row); end
        else if (b == 8'h08) begin
          if (m_col > 0) begin m_col--; push_ev(3, m_col); end
        end else if (b == 8'h09) begin
          m_col = (m_col / 8 + 1) * 8;
          if (m_col > 79) m_col = 79;
          push_ev(3, m_col);
        end else if (b == 8'h0C) begin
          push_ev(2, 0);
          push_ev(3, 0);
          for (int i = 0; i < 2400; i++) push_ev(1, 8'h20);
          m_row = 0; m_col = 0;
        end else if (b < 8'h20 || b == 8'h7F) begin
          // ignored code
        end else begin
          push_ev(1, b);
          m_col++;
          if (m_col == 80) begin m_col = 0; m_row = (m_row + 1) % 30; end
        end
      end
    endcase
  endtask

  // Returns #1 after the accepting clock edge.
  task automatic send_byte(input logic [7:0] b);
    int g = 0;
    @(negedge clk);
    while (!in_ready && g < 9000) begin @(negedge clk); g++; end
    if (g >= 9000) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: in_ready=%b, required 1 within 9000 cycles", in_ready);
    end
    in_data  = b;
    in_valid = 1'b1;
    model_byte(b);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    @(negedge clk);
    while (!(in_ready && !busy) && g < 9000) begin @(negedge clk); g++; end
    if (g >= 9000) begin
      n_tests++; n_fail++;
      $display("FAIL idle_timeout: busy=%b, required 0 within 9000 cycles", busy);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    exp_q.delete();
    m_row = 0; m_col = 0; m_esc = 0;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    n_tests++;
    if (data !== 8'h00 || dstb !== 1'b0 || rstb !== 1'b0 || cstb !== 1'b0 ||
        in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got data=%h d/r/c=%b%b%b ready=%b busy=%b, required 00 000 1 0",
               data, dstb, rstb, cstb, in_ready, busy);
    end
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (currow !== 5'd0 || curcol !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_cursor: got %0d,%0d, required 0,0", currow, curcol);
    end
  endtask

  task automatic test_char_timing();
    send_byte(8'h41);
    @(negedge clk);
    n_tests++;
    if (data !== 8'h41 || dstb !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL char_setup: got data=%h dstb=%b ready=%b busy=%b, required 41 0 0 1",
               data, dstb, in_ready, busy);
    end
    @(negedge clk);
    n_tests++;
    if (data !== 8'h41 || dstb !== 1'b1 || rstb !== 1'b0 || cstb !== 1'b0) begin
      n_fail++;
      $display("FAIL char_pulse: got data=%h d/r/c=%b%b%b, required 41 100", data, dstb, rstb, cstb);
    end
    @(negedge clk);
    n_tests++;
    if (data !== 8'h41 || dstb !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL char_hold: got data=%h dstb=%b ready=%b, required 41 0 0", data, dstb, in_ready);
    end
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || currow !== 5'd0 || curcol !== 7'd1) begin
      n_fail++;
      $display("FAIL char_done: got ready=%b busy=%b pos=%0d,%0d, required 1 0 0,1",
               in_ready, busy, currow, curcol);
    end
  endtask

  task automatic test_line_wrap();
    logic [7:0] b;
    do_reset();
    for (int i = 0; i < 80; i++) send_byte(8'h78);
    wait_idle();
    n_tests++;
    if (currow !== 5'd1 || curcol !== 7'd0) begin
      n_fail++;
      $display("FAIL wrap_line: got %0d,%0d, required 1,0", currow, curcol);
    end
    for (int i = 0; i < 28 * 80 + 79; i++) begin
      b = 8'($urandom_range(8'h20, 8'hFF));
      if (b == 8'h7F) b = 8'h80;
      send_byte(b);
    end
    wait_idle();
    n_tests++;
    if (currow !== 5'd29 || curcol !== 7'd79) begin
      n_fail++;
      $display("FAIL wrap_last: got %0d,%0d, required 29,79", currow, curcol);
    end
    send_byte(8'h78);
    wait_idle();
    n_tests++;
    if (currow !== 5'd0 || curcol !== 7'd0) begin
      n_fail++;
      $display("FAIL wrap_screen: got %0d,%0d, required 0,0", currow, curcol);
    end
  endtask

  task automatic test_ctrl();
    send_byte(8'h1B); send_byte(8'h3D); send_byte(8'h20); send_byte(8'h25);
    send_byte(8'h0D);
    wait_idle();
    n_tests++;
    if (currow !== 5'd0 || curcol !== 7'd0) begin
      n_fail++;
      $display("FAIL ctrl_cr: got %0d,%0d, required 0,0", currow, curcol);
    end
    send_byte(8'h0A);
    wait_idle();
    n_tests++;
    if (currow !== 5'd1 || curcol !== 7'd0) begin
      n_fail++;
      $display("FAIL ctrl_lf: got %0d,%0d, required 1,0", currow, curcol);
    end
    send_byte(8'h08);
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || curcol !== 7'd0) begin
      n_fail++;
      $display("FAIL ctrl_bs_col0: got ready=%b busy=%b col=%0d, required 1 0 0", in_ready, busy, curcol);
    end
    send_byte(8'h1B); send_byte(8'h3D); send_byte(8'h21); send_byte(8'h23);
    send_byte(8'h09);
    wait_idle();
    n_tests++;
    if (curcol !== 7'd8) begin
      n_fail++;
      $display("FAIL ctrl_tab: got col=%0d, required 8", curcol);
    end
    send_byte(8'h08);
    wait_idle();
    n_tests++;
    if (curcol !== 7'd7) begin
      n_fail++;
      $display("FAIL ctrl_bs: got col=%0d, required 7", curcol);
    end
    send_byte(8'h1B); send_byte(8'h3D); send_byte(8'h21); send_byte(8'h6E);
    send_byte(8'h09);
    send_byte(8'h09);
    wait_idle();
    n_tests++;
    if (currow !== 5'd1 || curcol !== 7'd79) begin
      n_fail++;
      $display("FAIL ctrl_tab_end: got %0d,%0d, required 1,79", currow, curcol);
    end
  endtask

  task automatic test_esc();
    send_byte(8'h1B); send_byte(8'h3D); send_byte(8'h25); send_byte(8'h2A);
    wait_idle();
    n_tests++;
    if (currow !== 5'd5 || curcol !== 7'd10) begin
      n_fail++;
      $display("FAIL esc_addr: got %0d,%0d, required 5,10", currow, curcol);
    end
    send_byte(8'h1B); send_byte(8'h3D); send_byte(8'h05); send_byte(8'h10);
    wait_idle();
    n_tests++;
    if (currow !== 5'd29 || curcol !== 7'd79) begin
      n_fail++;
      $display("FAIL esc_underflow: got %0d,%0d, required 29,79", currow, curcol);
    end
    send_byte(8'h1B); send_byte(8'h3D); send_byte(8'h25); send_byte(8'h2A);
    send_byte(8'h1B); send_byte(8'h3D); send_byte(8'h7F); send_byte(8'h7F);
    wait_idle();
    n_tests++;
    if (currow !== 5'd29 || curcol !== 7'd79) begin
      n_fail++;
      $display("FAIL esc_clamp: got %0d,%0d, required 29,79", currow, curcol);
    end
    send_byte(8'h1B); send_byte(8'h51);
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL esc_drop: got ready=%b busy=%b, required 1 0", in_ready, busy);
    end
    send_byte(8'h7F);
    send_byte(8'h00);
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ignored_byte: got ready=%b busy=%b, required 1 0", in_ready, busy);
    end
    send_byte(8'h41);
    wait_idle();
    n_tests++;
    if (currow !== 5'd0 || curcol !== 7'd0) begin
      n_fail++;
      $display("FAIL esc_then_char: got %0d,%0d, required 0,0", currow, curcol);
    end
  endtask

  task automatic test_clear();
    int cyc = 0;
    int d0;
    send_byte(8'h1B); send_byte(8'h3D); send_byte(8'h27); send_byte(8'h41);
    wait_idle();
    d0 = n_dstb;
    send_byte(8'h0C);
    @(negedge clk);
    while (busy && cyc < 8000) begin cyc++; @(negedge clk); end
    n_tests++;
    if (cyc != 7206) begin
      n_fail++;
      $display("FAIL clear_busy: got %0d cycles, required 7206", cyc);
    end
    n_tests++;
    if (n_dstb - d0 != 2400 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL clear_count: got %0d dstb (%0d events left), required 2400 (0 left)",
               n_dstb - d0, exp_q.size());
    end
    n_tests++;
    if (currow !== 5'd0 || curcol !== 7'd0) begin
      n_fail++;
      $display("FAIL clear_pos: got %0d,%0d, required 0,0", currow, curcol);
    end
  endtask

  task automatic abort_with_reset(input string name);
    reset = 1'b1;
    #1;
    n_tests++;
    if (dstb !== 1'b0 || rstb !== 1'b0 || cstb !== 1'b0 || in_ready !== 1'b1 ||
        currow !== 5'd0 || curcol !== 7'd0) begin
      n_fail++;
      $display("FAIL %s: got d/r/c=%b%b%b ready=%b pos=%0d,%0d, required 000 1 0,0",
               name, dstb, rstb, cstb, in_ready, currow, curcol);
    end
    exp_q.delete();
    m_row = 0; m_col = 0; m_esc = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    send_byte(8'h1B); send_byte(8'h3D); send_byte(8'h23); send_byte(8'h24);
    wait_idle();
    send_byte(8'h43);
    @(posedge clk);
    #2;
    n_tests++;
    if (dstb !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pulse_pre: got dstb=%b, required 1", dstb);
    end
    abort_with_reset("abort_dstb");
    send_byte(8'h0C);
    repeat (100) @(posedge clk);
    #2;
    abort_with_reset("abort_clear");
    send_byte(8'h42);
    wait_idle();
    n_tests++;
    if (currow !== 5'd0 || curcol !== 7'd1) begin
      n_fail++;
      $display("FAIL after_abort_char: got %0d,%0d, required 0,1", currow, curcol);
    end
  endtask

  initial begin
    test_reset();
    test_char_timing();
    test_line_wrap();
    test_ctrl();
    test_esc();
    test_clear();
    test_reset_mid();
    repeat (4) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL events_left: got %0d pending strobes, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
